// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the RV32E instruction fetch stage: state encoding and instruction constants.
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FAULT  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // addi x0,x0,0 and the jal x0,0 self-loop used as a halt idiom
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] HALT_WORD = 32'h0000_006F;

endpackage

// File: rtl/instr_fetch_pc.sv
// Program counter for the fetch stage: next-PC selection (hold / +4 / redirect)
// plus combinational alignment and ROM range checks.
module instr_fetch_pc
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned ROM_WORDS = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             load,
  input  logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  pc,
  output logic             misaligned_c,
  output logic             out_of_range_c
);

  // Redirect outranks sequential advance; wraps modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc + XLEN'(4);
    end
  end

  assign misaligned_c   = target[1:0] != 2'b00;
  assign out_of_range_c = (pc >> 2) >= XLEN'(ROM_WORDS);

endmodule

// File: rtl/instr_fetch.sv
// RV32E instruction fetch stage: drives the ROM address, captures instructions into a
// valid/ready output register, handles redirects and faults. Optional: INSTR_FETCH_HALT_DETECT_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned ROM_WORDS = 100
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
`ifdef INSTR_FETCH_HALT_DETECT_EN
  ,
  output logic        halted
`endif
);

  fetch_state_e state;

  logic is_run_c;
  logic redir_c;
  logic want_c;
  logic cap_c;
  logic load_c;
  logic advance_c;
  logic misaligned_c;
  logic out_of_range_c;
  logic halt_hit_c;

  instr_fetch_pc #(
    .RESET_PC  (RESET_PC),
    .ROM_WORDS (ROM_WORDS)
  ) u_pc (
    .clk            (clk),
    .rst            (rst),
    .advance        (advance_c),
    .load           (load_c),
    .target         (redirect_target),
    .pc             (rom_addr),
    .misaligned_c   (misaligned_c),
    .out_of_range_c (out_of_range_c)
  );

  assign is_run_c  = state == ST_RUN;
  assign redir_c   = is_run_c && redirect_valid;
  assign want_c    = is_run_c && (!out_valid || out_ready) && !redirect_valid;
  assign cap_c     = want_c && !out_of_range_c;
  assign load_c    = redir_c && !misaligned_c;
  // A captured halt word freezes the PC at the halt address
  assign advance_c = cap_c && !halt_hit_c;

`ifdef INSTR_FETCH_HALT_DETECT_EN
  assign halt_hit_c = rom_data == HALT_WORD;
`else
  assign halt_hit_c = 1'b0;
`endif

  // Output register, handshake and state machine; redirect has top priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      out_valid   <= 1'b0;
      out_instr   <= INSTR_NOP;
      out_pc      <= '0;
      fetch_fault <= 1'b0;
`ifdef INSTR_FETCH_HALT_DETECT_EN
      halted      <= 1'b0;
`endif
    end else begin
      if (redir_c) begin
        out_valid <= 1'b0;
        if (misaligned_c) begin
          state       <= ST_FAULT;
          fetch_fault <= 1'b1;
        end
      end else if (want_c && out_of_range_c) begin
        state       <= ST_FAULT;
        fetch_fault <= 1'b1;
        out_valid   <= 1'b0;
      end else if (cap_c) begin
        out_instr <= rom_data;
        out_pc    <= rom_addr;
        out_valid <= 1'b1;
`ifdef INSTR_FETCH_HALT_DETECT_EN
        if (halt_hit_c) begin
          state  <= ST_HALTED;
          halted <= 1'b1;
        end
`endif
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage of the RV32E core.
- Sits directly upstream of the program ROM: drives its byte address bus, consumes its combinational 32-bit data bus, and presents fetched instructions to decode with a valid/ready handshake.
- Owns the PC, sequential advance, branch/jump redirects, and detection of out-of-range or misaligned fetches.

Parameters:
- RESET_PC, 32'd0: byte address of the first fetch after reset.
- ROM_WORDS, 100: number of 32-bit words in the program ROM; a fetch at word index >= ROM_WORDS is a fault.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- rom_addr  output  32  byte address to ROM; always equals pc.
- rom_data  input  32  instruction word from ROM; combinational from rom_addr, same cycle.
- redirect_valid  input  1  taken branch/jump/JALR from execute.
- redirect_target  input  32  new byte PC when redirect_valid=1.
- out_valid  output  1  out_instr/out_pc hold a valid instruction.
- out_ready  input  1  decode accepts this cycle.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  byte address of out_instr.
- fetch_fault  output  1  sticky; misaligned redirect target or out-of-range fetch.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=RUN.
  - out_valid=0, out_instr=32'h00000013 (NOP), out_pc=0, fetch_fault=0.
- States: RUN, FAULT, and HALTED (HALTED exists only when the optional feature is compiled in).
- Fetch condition: cap = (state==RUN) && (!out_valid || out_ready) && !redirect_valid.
- On cap, in the same edge:
  - out_instr<=rom_data, out_pc<=pc, out_valid<=1, pc<=pc+4.
  - First instruction is visible one cycle after reset release; throughput is 1 instruction per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 && !redirect_valid. pc, out_instr and out_pc hold; out_valid stays 1; no ROM word is consumed.
- Drain without refill: state!=RUN and out_valid && out_ready gives out_valid<=0.
- Redirect (highest priority, in RUN):
  - out_valid<=0 (the in-flight instruction is discarded even if out_ready=1 the same cycle); pc<=redirect_target.
  - The fetch at the target occurs the next cycle, so a redirect costs exactly 1 bubble.
  - If redirect_target[1:0]!=0: pc is not updated; go to FAULT, fetch_fault<=1.
- Redirect in FAULT or HALTED: ignored.
- Range check: in RUN, if (pc>>2) >= ROM_WORDS when cap would be true, no capture takes place; go to FAULT, fetch_fault<=1, out_valid<=0.
- PC arithmetic: modulo 2^32; pc+4 wrapping past 32'hFFFFFFFC yields 0. The range check fires before any wrap for ROM_WORDS < 2^30.
- FAULT: terminal until rst. rom_addr keeps driving the frozen pc; out_valid=0; fetch_fault=1.
- Back-to-back redirects: the last one wins each cycle; no capture happens while redirect_valid=1.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately, independent of clk.

Optional Feature:
- Macro: INSTR_FETCH_HALT_DETECT_EN.
- With the macro:
  - When a capture yields rom_data==32'h0000006F (JAL x0,0, the self-loop halt idiom), the instruction is still delivered once (out_valid=1).
  - State goes to HALTED: pc frozen at the halt address, no further captures, redirect ignored.
  - Output port halted (1 bit, reset 0) asserts and stays 1 until rst.
- Without the macro: no halted port and no HALTED state. The self-loop is fetched repeatedly through normal redirects, like any other JAL.

Decomposition:
- Existing shared include instructions.v supplies I_NOP and OP_JAL; no duplicate definitions.
- New shared include fetch_defs.v holds the state encodings (RUN=2'd0, FAULT=2'd1, HALTED=2'd2) and the halt-word constant 32'h0000006F.
- One sub-module is natural: instr_fetch_pc, containing the PC register, next-PC mux (hold / +4 / redirect) and the alignment/range checks. instr_fetch holds the output register, handshake and state machine.

Test Plan:
- Reset with RESET_PC=0, out_ready=1 held -> out_pc = 0,4,8,12 on consecutive cycles; out_instr equals ROM words 0..3; first out_valid one cycle after rst falls.
- out_ready=0 for 3 cycles while out_pc=8 -> out_pc/out_instr stable at 8; rom_addr stays 12. Release -> next out_pc=12, no instruction skipped or duplicated.
- redirect_valid=1, target=24 while out_pc=16 is valid -> next cycle out_valid=0; the cycle after, out_pc=24.
- redirect target=26 -> fetch_fault=1 next cycle, out_valid=0. A later aligned redirect to 0 has no effect until rst.
- ROM_WORDS=4, sequential run from 0 -> words 0..3 delivered; at pc=16 fetch_fault=1 and no fifth instruction.
- With INSTR_FETCH_HALT_DETECT_EN, ROM word 4 = 32'h0000006F -> out_pc=16 delivered once, halted=1, no further out_valid. Without the macro, the same ROM plus execute redirects to 16 re-fetch it every 2 cycles.
